imem_boot_loader: RTL

Boot-time controller for the pipeline CPU's instruction memory. Owns the memory's address/write port and arbitrates it between the IF-stage fetch path and a byte-stream program loader. On request it holds the CPU, writes a length-prefixed program image into the memory word by word, then releases the CPU with a one-cycle restart pulse. Sits between the IF stage, the instruction memory, and the host byte source (UART receiver).

---
 rtl/imem_boot_loader.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/imem_boot_loader.sv
// Instruction-memory port owner: IF fetch when idle, byte-stream program loader on boot_req.
// Define IMEM_BOOT_CHECKSUM_EN to require a trailing XOR check byte after the image.
module imem_boot_loader #(
    parameter int MEM_SIZE = 512,
    parameter int ADDR_W   = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              boot_req,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic [31:0]       fetch_addr,
    output logic [31:0]       fetch_inst,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    input  logic [31:0]       mem_rdata,
    output logic              cpu_hold,
    output logic              boot_done,
    output logic              boot_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_FLUSH,
        S_ERROR
`ifdef IMEM_BOOT_CHECKSUM_EN
        , S_CHECK
`endif
    } state_e;

    localparam logic [15:0]   MAX_N   = 16'(MEM_SIZE);
    localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W + 1)'(1);

    state_e              state_q, state_d;
    logic [15:0]         len_q, len_d;
    logic [ADDR_W:0]     ptr_q, ptr_d;
    logic [1:0]          bcnt_q, bcnt_d;
    logic [23:0]         asm_q, asm_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic                we_q, we_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
`ifdef IMEM_BOOT_CHECKSUM_EN
    logic [7:0]          csum_q, csum_d;
`endif

    logic                accept;
    logic [15:0]         n_len;
    logic [ADDR_W:0]     ptr_inc;
    logic                unused_fetch;

    assign accept       = rx_valid && rx_ready;
    assign n_len        = {len_q[15:8], rx_data};
    assign ptr_inc      = ptr_q + PTR_ONE;
    assign unused_fetch = ^{fetch_addr[31:ADDR_W+2], fetch_addr[1:0]};

    assign cpu_hold   = (state_q != S_IDLE);
    assign fetch_inst = (state_q == S_IDLE) ? mem_rdata : 32'h0;
    assign mem_addr   = (state_q == S_IDLE) ? fetch_addr[ADDR_W+1:2] : waddr_q;
    assign mem_wdata  = wdata_q;
    assign mem_we     = we_q;
    assign boot_done  = done_q;
    assign boot_err   = err_q;

    always_comb begin
        rx_ready = 1'b0;
        case (state_q)
            S_LEN_HI, S_LEN_LO, S_DATA: rx_ready = 1'b1;
`ifdef IMEM_BOOT_CHECKSUM_EN
            S_CHECK: rx_ready = 1'b1;
`endif
            default: rx_ready = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        ptr_d   = ptr_q;
        bcnt_d  = bcnt_q;
        asm_d   = asm_q;
        wdata_d = wdata_q;
        waddr_d = waddr_q;
        we_d    = 1'b0;
        done_d  = 1'b0;
        err_d   = err_q;
`ifdef IMEM_BOOT_CHECKSUM_EN
        csum_d  = csum_q;
        if (accept && state_q != S_CHECK) csum_d = csum_q ^ rx_data;
`endif
        case (state_q)
            S_IDLE, S_ERROR: begin
                if (boot_req) begin
                    state_d = S_LEN_HI;
                    ptr_d   = '0;
                    bcnt_d  = '0;
                    err_d   = 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_d   = {rx_data, 8'h00};
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d = n_len;
                    if (n_len > MAX_N) begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                    end else if (n_len == 16'h0) begin
                        state_d = S_FLUSH;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    asm_d  = {asm_q[15:0], rx_data};
                    bcnt_d = bcnt_q + 2'd1;
                    // 4th byte: latch the word so the write lands next cycle
                    if (bcnt_q == 2'd3) begin
                        wdata_d = {asm_q, rx_data};
                        waddr_d = ptr_q[ADDR_W-1:0];
                        we_d    = 1'b1;
                        ptr_d   = ptr_inc;
                        if (ptr_inc == len_q[ADDR_W:0]) state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
`ifdef IMEM_BOOT_CHECKSUM_EN
                state_d = S_CHECK;
`else
                state_d = S_IDLE;
                done_d  = 1'b1;
`endif
            end
`ifdef IMEM_BOOT_CHECKSUM_EN
            S_CHECK: begin
                if (accept) begin
                    if (rx_data == csum_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            ptr_q   <= '0;
            bcnt_q  <= '0;
            asm_q   <= '0;
            wdata_q <= '0;
            waddr_q <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            ptr_q   <= ptr_d;
            bcnt_q  <= bcnt_d;
            asm_q   <= asm_d;
            wdata_q <= wdata_d;
            waddr_q <= waddr_d;
            we_q    <= we_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef IMEM_BOOT_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

endmodule
